fp_add_sequencer: RTL

FP_ADD_SEQUENCER -- requirements
Module: fp_add_sequencer

---
 rtl/fp_pkg.sv | 23 ++
 rtl/fp_shift_counter.sv | 29 ++
 rtl/fp_add_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared types and sizing helpers for the FP adder control path.
// Widths derive from the mantissa width so every user sizes alike.
package fp_pkg;

    typedef enum logic [5:0] {
        IDLE  = 6'b000001,
        CMP   = 6'b000010,
        ALIGN = 6'b000100,
        ADD   = 6'b001000,
        NORM  = 6'b010000,
        DONE  = 6'b100000
    } seq_state_t;

    // Alignment beyond guard/round/sticky reach is pointless.
    function automatic int shift_sat(input int ment_width);
        return ment_width + 3;
    endfunction

    function automatic int cnt_width(input int ment_width);
        return $clog2(ment_width + 4);
    endfunction

endpackage

// File: rtl/fp_shift_counter.sv
// Loadable down-counter with zero flag.
// Shared by the align and normalise phases.
module fp_shift_counter
    import fp_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/fp_add_sequencer.sv
// Control sequencer for a bit-serial FP adder datapath:
// compare, align, add, normalise, then hand off the result.
module fp_add_sequencer
    import fp_pkg::*;
#(
    parameter int MENT_WIDTH = 23,
    parameter int EXPO_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [EXPO_WIDTH:0] exp_diff_in,
    input  logic              sum_carry,
    input  logic              sum_msb,
    input  logic              sum_zero,
    input  logic              exp_zero,
    output logic              load_en,
    output logic              swap_sel,
    output logic              align_shift_en,
    output logic              add_en,
    output logic              norm_rshift_en,
    output logic              norm_lshift_en,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int SAT = shift_sat(MENT_WIDTH);
    localparam int CW  = cnt_width(MENT_WIDTH);
    localparam logic [CW-1:0]         SAT_C    = CW'(SAT);
    localparam logic [CW-1:0]         NORM_MAX = CW'(MENT_WIDTH + 1);
    localparam logic [CW-1:0]         ONE_C    = CW'(1);
    localparam logic [EXPO_WIDTH:0]   SAT_E    = (EXPO_WIDTH + 1)'(SAT);

    seq_state_t state, state_nxt;

    logic                diff_neg;
    logic [EXPO_WIDTH:0] mag;
    logic [CW-1:0]       sat_cnt;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       cnt_val;
    logic                cnt_zero;
    logic                cnt_load;
    logic                cnt_dec;
    logic                swap_q;
    logic                norm_first;
    logic                do_rsh;
    logic                do_lsh;

    assign diff_neg = exp_diff_in[EXPO_WIDTH];
    assign mag      = diff_neg ? (~exp_diff_in + 1'b1) : exp_diff_in;
    assign sat_cnt  = (mag >= SAT_E) ? SAT_C : mag[CW-1:0];

    // The normalise count starts full, so a full count marks NORM's first cycle.
    assign norm_first = (cnt == NORM_MAX);
    assign do_rsh     = norm_first && sum_carry;
    assign do_lsh     = !do_rsh && !sum_zero && !sum_msb
                        && !exp_zero && !cnt_zero;

    fp_shift_counter #(
        .WIDTH (CW)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            swap_q <= 1'b1;
        end else if (state == CMP) begin
            swap_q <= ~diff_neg;
        end else if (state == IDLE) begin
            swap_q <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (in_valid) state_nxt = CMP;
            CMP:   state_nxt = (sat_cnt != '0) ? ALIGN : ADD;
            ALIGN: if (cnt == ONE_C || cnt_zero) state_nxt = ADD;
            ADD:   state_nxt = NORM;
            NORM:  if (!do_lsh) state_nxt = DONE;
            DONE:  if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready       = 1'b0;
        load_en        = 1'b0;
        swap_sel       = swap_q;
        align_shift_en = 1'b0;
        add_en         = 1'b0;
        norm_rshift_en = 1'b0;
        norm_lshift_en = 1'b0;
        out_valid      = 1'b0;
        cnt_load       = 1'b0;
        cnt_dec        = 1'b0;
        cnt_val        = NORM_MAX;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                load_en  = in_valid;
            end
            CMP: begin
                swap_sel = ~diff_neg;
                cnt_load = 1'b1;
                cnt_val  = sat_cnt;
            end
            ALIGN: begin
                align_shift_en = 1'b1;
                cnt_dec        = 1'b1;
            end
            ADD: begin
                add_en   = 1'b1;
                cnt_load = 1'b1;
            end
            NORM: begin
                norm_rshift_en = do_rsh;
                norm_lshift_en = do_lsh;
                cnt_dec        = do_lsh;
            end
            DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

endmodule
